dec_dense_seq: RTL and testbench

- Sequential fully-connected decoder layer for the arrhythmia VAE.
- It is the counterpart of the encoder path. It consumes the sampled latent vector from the lambda layer when the controller pulses dec1_start or dec2_start, and produces the reconstruction.
- Computes out[j] = act(sum_i z[i]*w[j][i] + b[j]) using one time-multiplexed MAC, one product per cycle, with a start/done handshake.
- Two instances make up the decoder: N_IN=92/N_OUT=92/RELU=1, then N_IN=92/N_OUT=10/RELU=0.

---
 rtl/dec_dense_seq.sv | 187 ++++++++++++++++++
 tb/tb_dec_dense_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dec_dense_seq.sv
// Sequential fully-connected decoder layer: out[j] = act(sum_i z[i]*w[j][i] + b[j]).
// A single MAC is time-multiplexed over all products, one product per cycle.
// z, w and b are captured once at LOAD into shift registers, so the MAC always
// reads the low word. w is consumed linearly (row-major order), z is rotated so
// that it returns to element 0 at the end of every row, and b is shifted once
// per output.
module dec_dense_seq #(
  parameter int BITSIZE = 16,
  parameter int FRAC    = 8,
  parameter int N_IN    = 92,
  parameter int N_OUT   = 10,
  parameter int RELU    = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [BITSIZE*N_IN-1:0]       z,
  input  logic [BITSIZE*N_IN*N_OUT-1:0] w,
  input  logic [BITSIZE*N_OUT-1:0]      b,
  output logic                       busy,
  output logic                       done,
  output logic [BITSIZE*N_OUT-1:0]   out
);

  localparam int AW = 2*BITSIZE + $clog2(N_IN) + 1;
  localparam int IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int ZW = BITSIZE*N_IN;
  localparam int WW = BITSIZE*N_IN*N_OUT;
  localparam int BW = BITSIZE*N_OUT;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_MAC   = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Output word limits expressed at accumulator width for the saturation compare.
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-BITSIZE+1){1'b1}}, {(BITSIZE-1){1'b0}}};

  logic [2:0]             state_q, state_d;
  logic [IW-1:0]          i_q, i_d;
  logic [JW-1:0]          j_q, j_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic [ZW-1:0]          z_q, z_d;
  logic [WW-1:0]          w_q, w_d;
  logic [BW-1:0]          b_q, b_d;
  logic [BW-1:0]          out_q, out_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic signed [2*BITSIZE-1:0] prod_s;
  logic signed [AW-1:0]        prod_ext_s;
  logic signed [AW-1:0]        shifted_s;
  logic [BITSIZE-1:0]          res_s;
  logic [BW-1:0]               b_shift_s;

  // Sign-extend a bias word to accumulator width and align it to the product scale.
  function automatic logic signed [AW-1:0] bias_ext(input logic [BITSIZE-1:0] v);
    logic signed [AW-1:0] t;
    t = {{(AW-BITSIZE){v[BITSIZE-1]}}, v};
    return t <<< FRAC;
  endfunction

  assign prod_s     = $signed(z_q[BITSIZE-1:0]) * $signed(w_q[BITSIZE-1:0]);
  assign prod_ext_s = {{(AW-2*BITSIZE){prod_s[2*BITSIZE-1]}}, prod_s};
  assign shifted_s  = acc_q >>> FRAC;
  assign b_shift_s  = b_q >> BITSIZE;

  // Rescale, saturate and optionally rectify the finished accumulator.
  always_comb begin
    res_s = shifted_s[BITSIZE-1:0];
    if (shifted_s > SAT_MAX) begin
      res_s = SAT_MAX[BITSIZE-1:0];
    end else if (shifted_s < SAT_MIN) begin
      res_s = SAT_MIN[BITSIZE-1:0];
    end else begin
      res_s = shifted_s[BITSIZE-1:0];
    end
    if ((RELU == 1) && res_s[BITSIZE-1]) begin
      res_s = {BITSIZE{1'b0}};
    end else begin
      res_s = res_s;
    end
  end

  // Next-state logic for the LOAD / MAC / WRITE sequencer and its datapath.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    z_d     = z_q;
    w_d     = w_q;
    b_d     = b_q;
    out_d   = out_q;
    busy_d  = (state_q == S_LOAD) || (state_q == S_MAC) || (state_q == S_WRITE);
    done_d  = (state_q == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        z_d     = z;
        w_d     = w;
        b_d     = b;
        i_d     = {IW{1'b0}};
        j_d     = {JW{1'b0}};
        acc_d   = bias_ext(b[BITSIZE-1:0]);
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_d = acc_q + prod_ext_s;
        z_d   = (z_q >> BITSIZE) | (z_q << (BITSIZE*(N_IN-1)));
        w_d   = w_q >> BITSIZE;
        if (i_q == IW'(N_IN-1)) begin
          i_d     = {IW{1'b0}};
          state_d = S_WRITE;
        end else begin
          i_d     = i_q + {{(IW-1){1'b0}}, 1'b1};
          state_d = S_MAC;
        end
      end
      S_WRITE: begin
        for (int k = 0; k < N_OUT; k++) begin
          if (j_q == JW'(k)) begin
            out_d[BITSIZE*k +: BITSIZE] = res_s;
          end else begin
            out_d[BITSIZE*k +: BITSIZE] = out_q[BITSIZE*k +: BITSIZE];
          end
        end
        if (j_q == JW'(N_OUT-1)) begin
          state_d = S_DONE;
        end else begin
          j_d     = j_q + {{(JW-1){1'b0}}, 1'b1};
          i_d     = {IW{1'b0}};
          b_d     = b_shift_s;
          acc_d   = bias_ext(b_shift_s[BITSIZE-1:0]);
          state_d = S_MAC;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; synchronous active-low reset discards any partial run.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      i_q     <= {IW{1'b0}};
      j_q     <= {JW{1'b0}};
      acc_q   <= {AW{1'b0}};
      z_q     <= {ZW{1'b0}};
      w_q     <= {WW{1'b0}};
      b_q     <= {BW{1'b0}};
      out_q   <= {BW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      w_q     <= w_d;
      b_q     <= b_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;

endmodule

// File: tb/tb_dec_dense_seq.sv
// Scoreboard bench for dec_dense_seq: a RELU=1 and a RELU=0 instance share
// stimulus; each issued run pushes its hand-computed result and done cycle.
module tb_dec_dense_seq;

  localparam int B   = 16;
  localparam int NI  = 3;
  localparam int NO  = 2;
  localparam int LAT = 2 + NO*(NI+1);

  localparam logic [47:0] ZA = {16'hFF00, 16'h0200, 16'h0100};
  localparam logic [95:0] WA = {16'h0000, 16'hFF00, 16'hFF00, 16'h0100, 16'h0080, 16'h0100};
  localparam logic [31:0] BA = {16'h0000, 16'h0040};
  localparam logic [47:0] ZC = {16'h0001, 16'h0100, 16'h0080};
  localparam logic [95:0] WC = {16'h1234, 16'h0000, 16'hFF00, 16'h7FFF, 16'h0100, 16'h0200};
  localparam logic [31:0] BC = {16'h0020, 16'hFF80};
  localparam logic [47:0] ZS = {3{16'h7FFF}};
  localparam logic [95:0] WP = {6{16'h7FFF}};
  localparam logic [95:0] WN = {6{16'h8000}};

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [B*NI-1:0]    z = '0;
  logic [B*NI*NO-1:0] w = '0;
  logic [B*NO-1:0]    b = '0;
  logic busy1, done1, busy0, done0;
  logic [B*NO-1:0] out1, out0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bc1 = 0;
  int bc0 = 0;

  typedef struct {
    logic [31:0] o;
    int          t;
  } exp_t;
  exp_t q1[$];
  exp_t q0[$];
  exp_t m1, m0;

  dec_dense_seq #(.BITSIZE(B), .FRAC(8), .N_IN(NI), .N_OUT(NO), .RELU(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .z(z), .w(w), .b(b),
    .busy(busy1), .done(done1), .out(out1)
  );

  dec_dense_seq #(.BITSIZE(B), .FRAC(8), .N_IN(NI), .N_OUT(NO), .RELU(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .z(z), .w(w), .b(b),
    .busy(busy0), .done(done0), .out(out0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever a done pulse appears.
  always @(negedge clk) begin
    if (!reset) begin
      bc1 = 0;
      bc0 = 0;
    end else begin
      if (busy1) bc1++;
      if (busy0) bc0++;
      if (done1) begin
        if (q1.size() == 0) begin
          chk("relu1_unexpected_done", {31'd0, done1}, 32'd0);
        end else begin
          m1 = q1.pop_front();
          chk("relu1_out", out1, m1.o);
          chk("relu1_latency", cyc, m1.t);
          chk("relu1_busy_cycles", bc1, LAT-1);
        end
        bc1 = 0;
      end else if (q1.size() > 0 && cyc > q1[0].t) begin
        chk("relu1_done_missing", cyc, q1[0].t);
        void'(q1.pop_front());
      end
      if (done0) begin
        if (q0.size() == 0) begin
          chk("relu0_unexpected_done", {31'd0, done0}, 32'd0);
        end else begin
          m0 = q0.pop_front();
          chk("relu0_out", out0, m0.o);
          chk("relu0_latency", cyc, m0.t);
          chk("relu0_busy_cycles", bc0, LAT-1);
        end
        bc0 = 0;
      end else if (q0.size() > 0 && cyc > q0[0].t) begin
        chk("relu0_done_missing", cyc, q0[0].t);
        void'(q0.pop_front());
      end
    end
  end

  task automatic expect_at(input logic [31:0] e1, input logic [31:0] e0, input int t);
    exp_t x;
    x.o = e1; x.t = t; q1.push_back(x);
    x.o = e0; x.t = t; q0.push_back(x);
  endtask

  // Issue one start pulse; returns 1 time unit after the accepting edge.
  task automatic run(input logic [47:0] zv, input logic [95:0] wv, input logic [31:0] bv,
                     input logic [31:0] e1, input logic [31:0] e0);
    @(posedge clk); #1;
    z = zv; w = wv; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    expect_at(e1, e0, cyc + LAT);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q1.size() > 0 || q0.size() > 0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (q1.size() > 0 || q0.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d want 0 pending", q1.size() + q0.size());
      q1.delete();
      q0.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int c0;
    int nd;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {30'd0, busy1, busy0}, 32'd0);
    chk("reset_done", {30'd0, done1, done0}, 32'd0);
    chk("reset_out1", out1, 32'd0);
    chk("reset_out0", out0, 32'd0);
    reset = 1'b1;

    // Basic run, saturation both ways, truncation toward minus infinity.
    run(ZA, WA, BA, 32'h0000_0140, 32'hFD00_0140);
    drain();
    run(ZS, WP, 32'h0, 32'h7FFF_7FFF, 32'h7FFF_7FFF);
    drain();
    run(ZS, WN, 32'h0, 32'h0000_0000, 32'h8000_8000);
    drain();
    run(ZC, WC, BC, 32'h0000_01FF, 32'hFFB2_01FF);
    drain();

    // Inputs change right after LOAD; results must follow the latched values.
    run(ZA, WA, BA, 32'h0000_0140, 32'hFD00_0140);
    @(posedge clk); #1;
    z = ZS; w = WN; b = BC;
    drain();

    // Start pulses while busy must not disturb the run.
    run(ZC, WC, BC, 32'h0000_01FF, 32'hFFB2_01FF);
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    drain();

    // Reset during the MAC of output 1: no done, everything cleared.
    run(ZA, WA, BA, 32'h0000_0140, 32'hFD00_0140);
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    q1.delete();
    q0.delete();
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("midreset_busy", {30'd0, busy1, busy0}, 32'd0);
    chk("midreset_out1", out1, 32'd0);
    chk("midreset_out0", out0, 32'd0);
    nd = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done1 || done0) nd++;
    end
    chk("midreset_no_done", nd, 32'd0);
    run(ZC, WC, BC, 32'h0000_01FF, 32'hFFB2_01FF);
    drain();

    // Start held high: back-to-back runs every LAT+1 cycles.
    @(posedge clk); #1;
    z = ZA; w = WA; b = BA; start = 1'b1;
    @(posedge clk); #1;
    c0 = cyc;
    expect_at(32'h0000_0140, 32'hFD00_0140, c0 + LAT);
    expect_at(32'h0000_0140, 32'hFD00_0140, c0 + 2*LAT + 1);
    expect_at(32'h0000_0140, 32'hFD00_0140, c0 + 3*LAT + 2);
    repeat (23) @(posedge clk);
    #1 start = 1'b0;
    drain();
    repeat (15) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
